// File: rtl/ifetch_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_mem_responder_if
// Description : Bundle of the fetch-request side (cache asking/addr,
//               data/data_ready, flush, busy) and the byte-wide RAM side
//               (mem_a, mem_wr, mem_din) of the instruction-fetch responder.
//               slave  : the responder itself.
//               master : the cache/RAM environment around it.
// Ports       : req, req_addr, flush, mem_din         -> responder
//               mem_a, mem_wr, data, data_ready, busy -> environment
// Revision    : 1.0 - initial release
// ============================================================================
interface ifetch_mem_responder_if #(
    parameter int ADDR_W = 17
);
    logic              req;
    logic [31:0]       req_addr;
    logic              flush;
    logic [7:0]        mem_din;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic [31:0]       data;
    logic              data_ready;
    logic              busy;

    modport slave (
        input  req, req_addr, flush, mem_din,
        output mem_a, mem_wr, data, data_ready, busy
    );

    modport master (
        output req, req_addr, flush, mem_din,
        input  mem_a, mem_wr, data, data_ready, busy
    );
endinterface
`default_nettype wire

// File: rtl/ifetch_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_mem_responder
// Description : Memory-side responder for instruction fetch. On a one-cycle
//               request it walks a byte-wide synchronous RAM one byte per
//               cycle and returns a 16-bit compressed or a 32-bit instruction
//               with a one-cycle data_ready pulse. flush aborts a fetch.
// Ports       : clk, rst (sync, active-high)
//               bus (slave modport): req/req_addr/flush in, mem_a/mem_wr out,
//               mem_din in, data/data_ready/busy out.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_mem_responder #(
    parameter int ADDR_W = 17
) (
    input  wire logic               clk,
    input  wire logic               rst,
    ifetch_mem_responder_if.slave   bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RD   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [1:0]        r_idx;
    logic [31:0]       r_buf;
    logic [ADDR_W-1:0] r_a;
    logic [ADDR_W-1:0] r_mem_a;
    logic [31:0]       r_data;
    logic              r_data_ready;
    logic              w_busy;
    logic              w_compressed;
    logic              w_done;
    logic              w_unused;

    // Upper request-address bits are beyond the RAM and simply dropped.
    assign w_unused = ^bus.req_addr[31:ADDR_W];

    // At idx=1 the low byte is already in the buffer, so its two LSBs tell
    // whether this is a 16-bit instruction. idx=3 always completes.
    assign w_compressed = (r_idx == 2'd1) && (r_buf[1:0] != 2'b11);
    assign w_done       = w_compressed || (r_idx == 2'd3);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        if (bus.flush) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (bus.req) w_next_state = S_WAIT;
                S_WAIT:  w_next_state = S_RD;
                S_RD:    if (w_done) w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // ---------------- output logic ----------------
    // Derived only from the state register, so busy carries no input path.
    always_comb begin
        w_busy = (r_state != S_IDLE);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= 2'd0;
            r_buf        <= 32'h0;
            r_a          <= '0;
            r_mem_a      <= '0;
            r_data       <= 32'h0;
            r_data_ready <= 1'b0;
        end else begin
            r_data_ready <= 1'b0;
            if (bus.flush) begin
                r_idx <= 2'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.req) begin
                            r_a     <= bus.req_addr[ADDR_W-1:0];
                            r_mem_a <= bus.req_addr[ADDR_W-1:0];
                        end
                    end
                    S_WAIT: begin
                        r_mem_a <= r_a + ADDR_W'(1);
                        r_idx   <= 2'd0;
                    end
                    S_RD: begin
                        r_buf[{r_idx, 3'b000} +: 8] <= bus.mem_din;
                        if (w_compressed) begin
                            // Final byte comes straight from the RAM port.
                            r_data       <= {16'h0, bus.mem_din, r_buf[7:0]};
                            r_data_ready <= 1'b1;
                        end else if (r_idx == 2'd3) begin
                            r_data       <= {bus.mem_din, r_buf[23:0]};
                            r_data_ready <= 1'b1;
                        end else begin
                            // Address runs one byte ahead of the capture.
                            r_mem_a <= r_a + ADDR_W'(r_idx) + ADDR_W'(2);
                            r_idx   <= r_idx + 2'd1;
                        end
                    end
                    default: begin
                        r_idx <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign bus.mem_a      = r_mem_a;
    assign bus.mem_wr     = 1'b0;
    assign bus.data       = r_data;
    assign bus.data_ready = r_data_ready;
    assign bus.busy       = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_ifetch_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_mem_responder
// Description : Self-checking bench for ifetch_mem_responder. A cycle-level
//               transaction model predicts mem_a, data, data_ready and busy
//               every cycle; directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_mem_responder;
    localparam int AW   = 17;
    localparam int MASK = (1 << AW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ifetch_mem_responder_if #(.ADDR_W(AW)) bus();

    ifetch_mem_responder #(.ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Byte-wide synchronous RAM: data valid the cycle after the address.
    logic [7:0] ram [0:MASK];
    always @(posedge clk) bus.mem_din <= ram[bus.mem_a];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction model ----------------
    // An accepted fetch completes 3 edges later (16-bit) or 5 edges later
    // (32-bit); the address advances one byte per edge and stops at base+2
    // or base+4 respectively.
    bit          m_active = 1'b0;
    int          m_k      = 0;
    int          m_addr   = 0;
    bit          m_comp   = 1'b0;
    logic [16:0] e_mem_a  = '0;
    logic [31:0] e_data   = '0;
    logic        e_ready  = 1'b0;
    logic        e_busy   = 1'b0;

    function automatic logic [7:0] rb(input int base, input int off);
        return ram[(base + off) & MASK];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            e_mem_a  = '0;
            e_data   = '0;
            e_ready  = 1'b0;
            e_busy   = 1'b0;
        end else begin
            e_ready = 1'b0;
            if (bus.flush) begin
                m_active = 1'b0;
                e_busy   = 1'b0;
            end else if (m_active) begin
                m_k++;
                if (m_k <= (m_comp ? 2 : 4)) e_mem_a = 17'((m_addr + m_k) & MASK);
                if (m_k == (m_comp ? 3 : 5)) begin
                    e_ready  = 1'b1;
                    e_data   = m_comp ? {16'h0, rb(m_addr, 1), rb(m_addr, 0)}
                                      : {rb(m_addr, 3), rb(m_addr, 2), rb(m_addr, 1), rb(m_addr, 0)};
                    m_active = 1'b0;
                    e_busy   = 1'b0;
                end
            end else if (bus.req) begin
                m_active = 1'b1;
                m_k      = 0;
                m_addr   = int'(bus.req_addr) & MASK;
                m_comp   = (ram[m_addr][1:0] != 2'b11);
                e_mem_a  = 17'(m_addr);
                e_busy   = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("data_ready", 32'(bus.data_ready), 32'(e_ready));
            chk("busy",       32'(bus.busy),       32'(e_busy));
            chk("mem_a",      32'(bus.mem_a),      32'(e_mem_a));
            chk("mem_wr",     32'(bus.mem_wr),     32'h0);
            if (e_ready) chk("data", bus.data, e_data);
        end
    end

    // ---------------- pulse monitor ----------------
    int          pulses          = 0;
    int          last_pulse_cyc  = 0;
    logic [31:0] last_pulse_data = '0;
    logic        last_pulse_busy = 1'b0;
    bit          saw300          = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            if (bus.data_ready === 1'b1) begin
                pulses++;
                last_pulse_cyc  = cyc;
                last_pulse_data = bus.data;
                last_pulse_busy = bus.busy;
            end
            if (bus.mem_a == 17'h300) saw300 = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    // One call = one rising edge seeing the given inputs.
    task automatic step(input logic r, input logic [31:0] a, input logic f, input logic rs);
        @(negedge clk);
        #1;
        bus.req = r; bus.req_addr = a; bus.flush = f; rst = rs;
        @(posedge clk);
        #1;
        bus.req = 1'b0; bus.req_addr = 32'h0; bus.flush = 1'b0; rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    int p0, t0;
    logic [16:0] wrap_exp [4];

    initial begin
        bus.req = 1'b0; bus.req_addr = 32'h0; bus.flush = 1'b0;
        for (int i = 0; i <= MASK; i++) ram[i] = 8'h00;
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h10; ram[32'h103] = 8'h00;
        ram[32'h200] = 8'h05; ram[32'h201] = 8'h45;
        ram[32'h1FFFE] = 8'h13; ram[32'h1FFFF] = 8'h05; ram[0] = 8'h10; ram[1] = 8'h00;
        wrap_exp[0] = 17'h1FFFE; wrap_exp[1] = 17'h1FFFF; wrap_exp[2] = 17'h0; wrap_exp[3] = 17'h1;

        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk_en = 1'b1;
        chk("reset_data",  bus.data,              32'h0);
        chk("reset_busy",  32'(bus.busy),         32'h0);
        chk("reset_mem_a", 32'(bus.mem_a),        32'h0);
        chk("reset_ready", 32'(bus.data_ready),   32'h0);

        // 32-bit fetch
        p0 = pulses; step(1'b1, 32'h100, 1'b0, 1'b0); t0 = cyc; idle(7);
        chk("s1_count",   32'(pulses - p0),          32'd1);
        chk("s1_data",    last_pulse_data,           32'h00100513);
        chk("s1_latency", 32'(last_pulse_cyc - t0),  32'd5);

        // compressed fetch
        p0 = pulses; step(1'b1, 32'h200, 1'b0, 1'b0); t0 = cyc; idle(5);
        chk("s2_count",   32'(pulses - p0),          32'd1);
        chk("s2_data",    last_pulse_data,           32'h00004505);
        chk("s2_latency", 32'(last_pulse_cyc - t0),  32'd3);
        chk("s2_busy_at_ready", 32'(last_pulse_busy), 32'h0);

        // flush mid-fetch, then a new request right after
        p0 = pulses; step(1'b1, 32'h100, 1'b0, 1'b0); idle(2);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("s3_busy_after_flush", 32'(bus.busy), 32'h0);
        chk("s3_data_hold",        bus.data,      32'h00004505);
        step(1'b1, 32'h200, 1'b0, 1'b0); t0 = cyc; idle(5);
        chk("s3_count",   32'(pulses - p0),          32'd1);
        chk("s3_data",    last_pulse_data,           32'h00004505);
        chk("s3_latency", 32'(last_pulse_cyc - t0),  32'd3);

        // request while busy is ignored
        p0 = pulses; saw300 = 1'b0;
        step(1'b1, 32'h100, 1'b0, 1'b0); t0 = cyc; idle(1);
        step(1'b1, 32'h300, 1'b0, 1'b0); idle(6);
        chk("s4_count",   32'(pulses - p0),          32'd1);
        chk("s4_data",    last_pulse_data,           32'h00100513);
        chk("s4_latency", 32'(last_pulse_cyc - t0),  32'd5);
        chk("s4_no_300",  32'(saw300),               32'h0);

        // address wrap-around
        p0 = pulses; step(1'b1, 32'h1FFFE, 1'b0, 1'b0); t0 = cyc;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            chk("s5_mem_a_seq", 32'(bus.mem_a), 32'(wrap_exp[k]));
        end
        idle(4);
        chk("s5_count", 32'(pulses - p0), 32'd1);
        chk("s5_data",  last_pulse_data,  32'h00100513);

        // reset mid-operation
        p0 = pulses; step(1'b1, 32'h100, 1'b0, 1'b0); idle(1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("s6_data",  bus.data,            32'h0);
        chk("s6_busy",  32'(bus.busy),       32'h0);
        chk("s6_mem_a", 32'(bus.mem_a),      32'h0);
        chk("s6_ready", 32'(bus.data_ready), 32'h0);
        step(1'b1, 32'h200, 1'b0, 1'b0); t0 = cyc; idle(5);
        chk("s6_count",   32'(pulses - p0),          32'd1);
        chk("s6_data_after", last_pulse_data,        32'h00004505);
        chk("s6_latency", 32'(last_pulse_cyc - t0),  32'd3);

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ifetch_mem_responder.md
# ifetch_mem_responder

Memory-side responder for the instruction-fetch request interface. Accepts a one-cycle fetch request carrying a byte address and reads the instruction from a byte-wide synchronous RAM one byte per cycle. It returns a 16-bit compressed or 32-bit instruction with a one-cycle `data_ready` pulse. It sits between the instruction cache's `asking`/`addr` outputs and the unified RAM, and feeds the cache's `data`/`data_ready` inputs.

## Interface
- `ADDR_W`, default 17: RAM address width. Request addresses are truncated to this width.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous, active-high; clock `clk`.
- `req`  in  1: fetch request, one-cycle pulse (the cache's `asking`).
- `req_addr`  in  32: byte address of the instruction (the cache's `addr`).
- `flush`  in  1: abort any fetch in progress (pipeline redirect).
- `mem_din`  in  8: RAM read data, valid the cycle after `mem_a` is presented.
- `mem_a`  out  ADDR_W: RAM byte address, registered.
- `mem_wr`  out  1: RAM write enable; constant 0.
- `data`  out  32: fetched instruction.
- `data_ready`  out  1: one-cycle pulse; `data` is valid while it is high.
- `busy`  out  1: high in every state except IDLE, registered.

## Operation
- States:
  - IDLE.
  - WAIT: first RAM access in flight.
  - RD: byte capture; 2-bit index `idx`, byte buffer `buf[31:0]`, latched base `a`.
- IDLE:
  - When `req`=1 and `flush`=0: latch `a`=`req_addr[ADDR_W-1:0]`, set `mem_a`<=`a`, go to WAIT.
  - `req` while not IDLE is ignored; no queueing, no error.
- WAIT: `mem_a`<=`a`+1, `idx`<=0, go to RD.
- RD, each edge:
  - Capture `mem_din` into `buf[8*idx+7:8*idx]`, then apply the exit rules below.
  - `idx`=1 and `buf[1:0]`!=2'b11 (compressed): `data`<={16'h0, `mem_din`, `buf[7:0]`}, `data_ready`<=1, go to IDLE.
  - `idx`=3: `data`<={`mem_din`, `buf[23:0]`}, `data_ready`<=1, go to IDLE.
  - Otherwise: `mem_a`<=`a`+`idx`+2, `idx`<=`idx`+1.
- Address arithmetic is modulo 2^ADDR_W. An address of all ones followed by +1 wraps to 0.
- Extra addresses issued past a compressed instruction are harmless; the interface is read-only.
- `data` holds its last value until the next completion. `mem_a` holds its last value in IDLE.
- `flush`:
  - In any state: go to IDLE, `idx`<=0, suppress `data_ready`. `data` is not updated.
  - `flush` wins over a simultaneous `req` and over a completion in the same cycle.
- `rst`, in any state including mid-fetch:
  - State IDLE; outputs `mem_a`=0, `data`=0, `data_ready`=0, `busy`=0, `mem_wr`=0.
  - `buf`, `a` and `idx` cleared.

## Timing
- `req` sampled at edge N with no flush:
  - `mem_a`=addr after N.
  - addr+1 after N+1.
  - addr+2 after N+2.
  - addr+3 after N+3 (32-bit case only).
- Compressed instruction: `data_ready` high for the single cycle after edge N+3.
- 32-bit instruction: `data_ready` high for the single cycle after edge N+5.
- `busy` is high from after N until the edge that raises `data_ready`; it is low in the cycle `data_ready` is high.
- Earliest next accepted request is at the edge ending the `data_ready` cycle. Back-to-back fetches run every 4 or 6 cycles.
- `flush` at edge M: `busy`=0 after M. A `req` at M+1 is accepted normally.
- No combinational path from any input to any output.

## Test plan
- 32-bit fetch:
  - Stimulus: RAM[0x100..0x103]=13 05 10 00; `req` with addr 0x100 at edge N.
  - Response: `mem_a` sequence 0x100, 0x101, 0x102, 0x103; `data`=0x00100513 with `data_ready` after N+5, exactly one cycle.
- Compressed fetch:
  - Stimulus: RAM[0x200..0x201]=05 45; `req` with addr 0x200.
  - Response: `data`=0x00004505, `data_ready` after N+3; `busy` low in the same cycle.
- Flush mid-fetch:
  - Stimulus: 32-bit fetch at 0x100; `flush` at N+3.
  - Response: no `data_ready`; `data` unchanged; `busy`=0 after N+3.
  - Follow-up: new `req` at N+4 for 0x200 completes after N+7 with 0x00004505.
- Request while busy:
  - Stimulus: extra `req` with addr 0x300 at N+2 during the 0x100 fetch.
  - Response: ignored; the single `data_ready` after N+5 carries 0x00100513; `mem_a` never equals 0x300.
- Wrap-around:
  - Setup: ADDR_W=17.
  - Stimulus: `req` with addr 0x1FFFE, where RAM[0x1FFFE..0x1FFFF]=13 05 and RAM[0..1]=10 00.
  - Response: `mem_a` sequence 0x1FFFE, 0x1FFFF, 0x0, 0x1; `data`=0x00100513.
- Reset mid-operation:
  - Stimulus: `rst` at N+2 of a fetch.
  - Response: all outputs at reset values after N+2; no `data_ready`; `req` at N+3 is accepted normally.
